ndata_serializer: RTL



---
 rtl/ndata_serializer_pkg.sv | 44 ++++
 rtl/ndata_serializer_lsb_priority_enc.sv | 20 ++
 rtl/ndata_serializer_skid.sv | 65 ++++++
 rtl/ndata_serializer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ndata_serializer_pkg.sv
// Shared types, sizing constants and mask helpers for the ndata serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ndata_serializer_pkg;

    // Default lane count and the widest lane count the helpers support.
    localparam int NUM_ELEMENTS_DEFAULT = 8;
    localparam int MAX_ELEMENTS         = 64;
    localparam int MAX_IDX_BITS         = 6;

    // Index width for the default lane count (a 1-lane build still needs one bit).
    localparam int IDX_BITS = (NUM_ELEMENTS_DEFAULT > 1) ? $clog2(NUM_ELEMENTS_DEFAULT) : 1;

    // Element carried per lane and per output beat.
    typedef logic [31:0] data_t;
    localparam int DATA_W = $bits(data_t);

    // One narrow output beat; also the payload of the optional output skid stage.
    typedef struct packed {
        data_t data;
        logic  keep;
        logic  last;
    } out_beat_t;

    localparam logic [MAX_ELEMENTS-1:0] MASK_ONE = {{(MAX_ELEMENTS-1){1'b0}}, 1'b1};

    // Index of the lowest set bit; returns 0 for an all-zero mask.
    function automatic logic [MAX_IDX_BITS-1:0] lowest_set_idx(input logic [MAX_ELEMENTS-1:0] mask);
        logic [MAX_IDX_BITS-1:0] idx;
        idx = '0;
        for (int i = MAX_ELEMENTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = MAX_IDX_BITS'(i);
            end
        end
        return idx;
    endfunction

    // True when at most one bit of the mask is set.
    function automatic logic is_onehot_or_zero(input logic [MAX_ELEMENTS-1:0] mask);
        return (mask & (mask - MASK_ONE)) == '0;
    endfunction

endpackage

// File: rtl/ndata_serializer_lsb_priority_enc.sv
// Lowest-set-bit priority encoder over a lane mask.
// Latency: combinational.
// Backpressure: none (pure function of mask_i).
module ndata_serializer_lsb_priority_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    import ndata_serializer_pkg::*;

    // Zero-extend to the helper's fixed width; an empty mask yields index 0.
    always_comb begin
        idx_o = IDX_W'(lowest_set_idx(MAX_ELEMENTS'(mask_i)));
        any_o = |mask_i;
    end

endmodule

// File: rtl/ndata_serializer_skid.sv
// Two-entry output skid stage; only built when NDATA_SERIALIZER_SKID_EN is defined.
// Latency: one cycle from input accept to out_valid_o.
// Backpressure: in_ready_o is registered (low only while the skid slot is full).
`ifdef NDATA_SERIALIZER_SKID_EN
module ndata_serializer_skid #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // The skid slot absorbs the one beat that arrives in the cycle the output stalls.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_ready_i || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid_i;
                if (in_valid_i) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (in_valid_i && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    // Output and skid registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule
`endif

// File: rtl/ndata_serializer.sv
// Wide-to-narrow serializer: emits kept lanes of each beat in ascending order, one per cycle; optional output skid via NDATA_SERIALIZER_SKID_EN.
// Latency: 1 cycle accept->first out_valid_o (2 with NDATA_SERIALIZER_SKID_EN).
// Backpressure: in_ready_o only on the final emit of the held beat; without the skid it depends combinationally on out_ready_i.
module ndata_serializer #(
    parameter int NUM_ELEMENTS = ndata_serializer_pkg::NUM_ELEMENTS_DEFAULT
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_ELEMENTS*ndata_serializer_pkg::DATA_W-1:0] in_data_i,
    input  logic [NUM_ELEMENTS-1:0]                        in_keep_i,
    input  logic                                           in_last_i,
    input  logic                                           in_valid_i,
    output logic                                           in_ready_o,
    output logic [ndata_serializer_pkg::DATA_W-1:0]        out_data_o,
    output logic                                           out_keep_o,
    output logic                                           out_last_o,
    output logic                                           out_valid_o,
    input  logic                                           out_ready_i
);
    import ndata_serializer_pkg::*;

    localparam int DW    = DATA_W;
    localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam logic [NUM_ELEMENTS-1:0] LANE_ONE = {{(NUM_ELEMENTS-1){1'b0}}, 1'b1};

    // Hold register: the accepted wide beat plus the lanes still to be emitted.
    logic [NUM_ELEMENTS*DW-1:0] data_q, data_d;
    logic [NUM_ELEMENTS-1:0]    rem_q, rem_d;
    logic                       last_q, last_d;
    logic                       hold_valid_q, hold_valid_d;

    logic [IDX_W-1:0] idx;
    logic             any;
    logic             final_emit;
    logic             emit_rdy;
    logic             load;
    logic             in_ready;
    out_beat_t        beat;

    ndata_serializer_lsb_priority_enc #(
        .WIDTH (NUM_ELEMENTS),
        .IDX_W (IDX_W)
    ) u_enc (
        .mask_i (rem_q),
        .idx_o  (idx),
        .any_o  (any)
    );

    // Current narrow beat from the hold register; an empty terminator (rem==0) reads lane 0.
    always_comb begin
        final_emit = is_onehot_or_zero(MAX_ELEMENTS'(rem_q));
        beat.data  = data_q[idx*DW +: DW];
        beat.keep  = any;
        beat.last  = last_q && final_emit;
    end

    // A new beat may enter when the hold is empty or its last element leaves this cycle.
    always_comb begin
        in_ready = !hold_valid_q || (emit_rdy && final_emit);
        load     = in_valid_i && in_ready;
    end

    // Next state: load overrides the final emit; keep==0 && last==0 beats never become valid.
    always_comb begin
        data_d       = data_q;
        rem_d        = rem_q;
        last_d       = last_q;
        hold_valid_d = hold_valid_q;
        if (load) begin
            data_d       = in_data_i;
            rem_d        = in_keep_i;
            last_d       = in_last_i;
            hold_valid_d = (|in_keep_i) || in_last_i;
        end else if (hold_valid_q && emit_rdy) begin
            rem_d = rem_q & ~(LANE_ONE << idx);
            if (final_emit) begin
                hold_valid_d = 1'b0;
            end
        end
    end

    // Hold register update; reset discards any partially emitted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= '0;
            rem_q        <= '0;
            last_q       <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            rem_q        <= rem_d;
            last_q       <= last_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign in_ready_o = in_ready;

`ifdef NDATA_SERIALIZER_SKID_EN
    out_beat_t skid_beat;

    ndata_serializer_skid #(
        .WIDTH ($bits(out_beat_t))
    ) u_skid (
        .clk         (clk),
        .rst_n       (!rst),
        .in_valid_i  (hold_valid_q),
        .in_ready_o  (emit_rdy),
        .in_data_i   (beat),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (skid_beat)
    );

    assign out_data_o = skid_beat.data;
    assign out_keep_o = skid_beat.keep;
    assign out_last_o = skid_beat.last;
`else
    assign emit_rdy    = out_ready_i;
    assign out_valid_o = hold_valid_q;
    assign out_data_o  = beat.data;
    assign out_keep_o  = beat.keep;
    assign out_last_o  = beat.last;
`endif

endmodule
